// File: rtl/hsi_m_sdreq_sched_pkg.sv
// -----------------------------------------------------------------------------
// hsi_m_sdreq_sched_pkg
// Shared definitions for the HSI master SR/DPR polling scheduler:
//   - state and command encodings
//   - default poll period (100 us) and reply timeout (20 us) derived from the
//     system clock frequency
//   - timer width helper: clog2(max(POLL_PERIOD, REPLY_TIMEOUT))
// -----------------------------------------------------------------------------
package hsi_m_sdreq_sched_pkg;

  localparam int unsigned CLK_FREQ_HZ       = 100_000_000;
  localparam int unsigned DEF_POLL_PERIOD   = CLK_FREQ_HZ / 10_000;  // 100 us
  localparam int unsigned DEF_REPLY_TIMEOUT = CLK_FREQ_HZ / 50_000;  // 20 us

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PERIOD = 3'd1,
    ST_REQ    = 3'd2,
    ST_SENT   = 3'd3,
    ST_REPLY  = 3'd4,
    ST_FAIL   = 3'd5
  } state_e;

  typedef enum logic {
    CMD_SR  = 1'b0,
    CMD_DPR = 1'b1
  } cmd_e;

  // The timer only ever needs to reach max(...)-1, so clog2 of the max fits.
  function automatic int unsigned timer_width(input int unsigned a,
                                              input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/hsi_m_sdreq_sched_tick.sv
// -----------------------------------------------------------------------------
// hsi_tick_timer
// Up-counter with synchronous clear and a terminal-count compare. Shared by the
// scheduler's PERIOD and REPLY phases; the owner selects the terminal value.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   clr_i       synchronous clear (takes priority over counting)
//   en_i        count enable
//   tc_i        terminal count value
//   count_o     current count
//   tc_o        count_o == tc_i (decoded from the count register)
// -----------------------------------------------------------------------------
module hsi_tick_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] tc_i,
  output logic [W-1:0] count_o,
  output logic         tc_o
);

  logic [W-1:0] count_q, count_d;

  assign tc_o    = (count_q == tc_i);
  assign count_o = count_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    count_d = count_q;
    if (clr_i)              count_d = '0;
    else if (en_i && !tc_o) count_d = count_q + 1'b1;  // hold at terminal
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments for state so every register samples
    // values from before the edge, independent of statement order.
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/hsi_m_sdreq_sched.sv
// -----------------------------------------------------------------------------
// hsi_m_sdreq_sched
// Polling scheduler for HSI master service-request (SR) and data-port-read (DPR)
// traffic. Periodically requests an SR frame, waits for the reply, follows up
// with a DPR frame when the slave flags pending data, retries on reply error or
// timeout, and raises a sticky link failure once the retry budget is spent.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   sched_en            polling enable (level)
//   sr_tx_rdy/sr_tx_ack   SR frame request / TX controller sending SR
//   dpr_tx_rdy/dpr_tx_ack DPR frame request / TX controller sending DPR
//   frame_to_reply_end  pulse: last CRC byte of the request frame sent
//   reply_ok/reply_err  pulses: valid reply / reply with bad CRC or format
//   dpr_pending         slave data-pending flag, qualified by reply_ok
//   busy                transaction in flight (REQ, SENT, REPLY)
//   timeout             1-cycle pulse, registered: high in the cycle after the
//                       reply timer expired (first cycle of the retry/fail)
//   link_fail           sticky failure flag, cleared by dropping sched_en
//   retry_cnt           retries already spent on the current command
// -----------------------------------------------------------------------------
module hsi_m_sdreq_sched
  import hsi_m_sdreq_sched_pkg::*;
#(
  parameter int unsigned POLL_PERIOD   = DEF_POLL_PERIOD,
  parameter int unsigned REPLY_TIMEOUT = DEF_REPLY_TIMEOUT,
  parameter int unsigned MAX_RETRIES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sched_en,
  output logic       sr_tx_rdy,
  input  logic       sr_tx_ack,
  output logic       dpr_tx_rdy,
  input  logic       dpr_tx_ack,
  input  logic       frame_to_reply_end,
  input  logic       reply_ok,
  input  logic       reply_err,
  input  logic       dpr_pending,
  output logic       busy,
  output logic       timeout,
  output logic       link_fail,
  output logic [1:0] retry_cnt
);

  localparam int unsigned TW       = timer_width(POLL_PERIOD, REPLY_TIMEOUT);
  localparam logic [TW-1:0] POLL_TC  = TW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] REPLY_TC = TW'(REPLY_TIMEOUT - 1);
  localparam logic [1:0]    MAX_RC   = 2'(MAX_RETRIES);

  state_e     state_q, state_d;
  cmd_e       cmd_q, cmd_d;
  logic [1:0] retry_q, retry_d;
  logic       timeout_q, timeout_d;

  logic          tmr_tc;
  logic [TW-1:0] tmr_count;
  logic          ack_match;

  assign ack_match = (cmd_q == CMD_SR) ? sr_tx_ack : dpr_tx_ack;

  // Clearing on any state change guarantees a zero count on every entry into
  // PERIOD and REPLY, so the counter never has to wrap.
  hsi_tick_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (state_d != state_q),
    .en_i    ((state_q == ST_PERIOD) || (state_q == ST_REPLY)),
    .tc_i    ((state_q == ST_REPLY) ? REPLY_TC : POLL_TC),
    .count_o (tmr_count),
    .tc_o    (tmr_tc)
  );

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    retry_d   = retry_q;
    timeout_d = 1'b0;
    unique case (state_q)
      ST_IDLE:   if (sched_en) state_d = ST_PERIOD;
      ST_PERIOD: begin
        if (!sched_en) state_d = ST_IDLE;
        else if (tmr_tc) begin
          state_d = ST_REQ;
          cmd_d   = CMD_SR;
          retry_d = '0;
        end
      end
      // An ack seen together with a disable still commits the frame.
      ST_REQ: begin
        if (ack_match)      state_d = ST_SENT;
        else if (!sched_en) state_d = ST_IDLE;
      end
      ST_SENT:   if (frame_to_reply_end) state_d = ST_REPLY;
      // Once a frame is out, a disable only redirects PERIOD/REQ exits to IDLE.
      ST_REPLY: begin
        if (reply_ok) begin
          if ((cmd_q == CMD_SR) && dpr_pending) begin
            state_d = sched_en ? ST_REQ : ST_IDLE;
            cmd_d   = CMD_DPR;
            retry_d = '0;
          end else begin
            state_d = sched_en ? ST_PERIOD : ST_IDLE;
          end
        end else if (reply_err || tmr_tc) begin
          timeout_d = !reply_err;
          if (retry_q < MAX_RC) begin
            retry_d = retry_q + 1'b1;
            state_d = sched_en ? ST_REQ : ST_IDLE;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_FAIL:   if (!sched_en) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (state_d == ST_IDLE) retry_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cmd_q     <= CMD_SR;
      retry_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      retry_q   <= retry_d;
      timeout_q <= timeout_d;
    end
  end

  assign sr_tx_rdy  = (state_q == ST_REQ) && (cmd_q == CMD_SR);
  assign dpr_tx_rdy = (state_q == ST_REQ) && (cmd_q == CMD_DPR);
  assign busy       = (state_q == ST_REQ) || (state_q == ST_SENT) ||
                      (state_q == ST_REPLY);
  assign link_fail  = (state_q == ST_FAIL);
  assign timeout    = timeout_q;
  assign retry_cnt  = retry_q;

endmodule
